ref_level_tracker: RTL and testbench
====================================

Name: ref_level_tracker

Overview:
- Parametrised successor to the fixed-window slicer reference generator in the demodulator back end.
- Accumulates |dec_var| over a 2^WIN_LOG2-symbol window, sequences windows by itself, and publishes a new reference level at the end of each window.
- Derives an average-power estimate through a registered two-stage multiply pipeline and flags each update with a strobe.
- Feeds the slicer (ref_level) and the MER/AGC logic (avg_power).

Parameters:
- DATA_W, 18: width of dec_var, ref_level and avg_power; signed, 1s(DATA_W-1) format.
- WIN_LOG2, 10: log2 of the window length in symbols.
- POWER_SCALE, 18'sd81920: power gain in 2s16 format (1.25 for 4-ASK).
- ALPHA_LOG2, 3: smoothing shift. Used only with REF_LEVEL_EMA_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- clk_en  in  1  symbol-rate enable; one dec_var sample per asserted cycle
- start  in  1  IDLE -> ACQ; ignored in other states
- hold  in  1  freeze accumulation and window counter
- clear  in  1  discard the current partial window
- dec_var  in  DATA_W  signed decision variable
- ref_level  out  DATA_W  registered reference level, non-negative
- avg_power  out  DATA_W  registered power estimate, 1s(DATA_W-1)
- est_valid  out  1  one-clk pulse when avg_power updates
- locked  out  1  high once the first full window has completed
- sym_cnt  out  WIN_LOG2  symbols accumulated in the current window

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator 0; pipeline registers 0. Reset is sampled only on the clk edge.
- States:
  - IDLE: no accumulation; start=1 -> ACQ.
  - ACQ: accumulates; on window completion -> TRACK, locked<=1.
  - TRACK: accumulates and updates every window; stays in TRACK until reset.
- Accumulation:
  - Accumulator is DATA_W+WIN_LOG2 bits wide.
  - On clk_en in ACQ/TRACK with hold=0: acc += |dec_var| and sym_cnt += 1.
  - |x| saturates: the most-negative input maps to 2^(DATA_W-1)-1.
- Window end: the clk_en sample that accumulates with sym_cnt==2^WIN_LOG2-1. On that edge:
  - new_ref = (acc + |dec_var|) >>> WIN_LOG2, registered into ref_level.
  - acc <= 0 and sym_cnt wraps to 0. The next sample starts the next window; no samples are lost.
- Power pipeline: free-running on clk, not gated by clk_en.
  - Stage 1, edge after the ref_level update: sq = ref_level^2 (2s34), keep bits [2*DATA_W-2 : DATA_W-1].
  - Stage 2, next edge: product with POWER_SCALE (3s33), keep bits [2*DATA_W-3 : DATA_W-2] into avg_power.
  - est_valid pulses on the same edge that avg_power updates, i.e. 2 clk after ref_level changes.
- hold=1: accumulator, sym_cnt and state frozen; ref_level and avg_power held; a pipeline already in flight completes.
- clear=1: acc <= 0 and sym_cnt <= 0. ref_level, avg_power, locked and state are unchanged. clear takes priority over the clk_en sample in the same cycle, so that sample is discarded.
- Simultaneous events: priority is reset > clear > hold > accumulate.
- start while not in IDLE: ignored.
- clk_en low: no state change except the power pipeline draining.

Optional Feature:
- REF_LEVEL_EMA_EN defined:
  - ref_level <= ref_level + ((new_ref - ref_level) >>> ALPHA_LOG2), arithmetic shift.
  - Computed at DATA_W+1 bits, then saturated to [0, 2^(DATA_W-1)-1].
  - Exception: the first window in ACQ loads new_ref directly.
- Not defined: ref_level <= new_ref every window.

Test Plan (DATA_W=18, WIN_LOG2=4, POWER_SCALE=81920, EMA off unless stated):
- reset, start, dec_var=+65536 for 16 clk_en -> ref_level=65536, locked=1; 2 clk later avg_power=40960 with est_valid pulsed once.
- Alternating dec_var +65536/-65536 for 16 symbols -> ref_level=65536, avg_power=40960, sym_cnt back to 0.
- dec_var=-131072 for 16 symbols -> saturated |x|, ref_level=131071, no overflow or sign flip.
- hold=1 for 5 clk_en mid-window (after 8 symbols), then 8 more symbols of +65536 -> update occurs after 16 accumulated symbols total; sym_cnt frozen at 8 during hold.
- clear after 10 symbols of +131071, then 16 symbols of +32768 -> ref_level=32768; locked unchanged; reset mid-window -> all outputs 0, state IDLE, start required again.
- REF_LEVEL_EMA_EN, ALPHA_LOG2=2, constant +65536 -> windows 1 and 2 both give 65536 (first window loads directly). Then constant +32768 -> 57344, then 51200.

Source files
------------

// File: rtl/ref_level_tracker_if.sv
// ----------------------------------------------------------------------------
// ref_level_tracker_if
//
// Groups the symbol-rate control/data inputs and the published estimates of
// ref_level_tracker into one bundle. clk and reset stay plain ports on the
// module itself.
//
//   master modport (driver / consumer side):
//     out: clk_en, start, hold, clear, dec_var
//     in : ref_level, avg_power, est_valid, locked, sym_cnt
//   slave modport (ref_level_tracker side): the same signals, reversed.
// ----------------------------------------------------------------------------
interface ref_level_tracker_if #(
    parameter int DATA_W   = 18,
    parameter int WIN_LOG2 = 10
);
    logic                       clk_en;     // one dec_var sample per asserted cycle
    logic                       start;      // IDLE -> ACQ request
    logic                       hold;       // freeze accumulation and window counter
    logic                       clear;      // drop the current partial window
    logic signed [DATA_W-1:0]   dec_var;    // decision variable, 1s(DATA_W-1)
    logic signed [DATA_W-1:0]   ref_level;  // slicer reference, never negative
    logic signed [DATA_W-1:0]   avg_power;  // power estimate, 1s(DATA_W-1)
    logic                       est_valid;  // one-clk pulse when avg_power updates
    logic                       locked;     // first full window has completed
    logic        [WIN_LOG2-1:0] sym_cnt;    // symbols in the current window

    modport master (
        output clk_en, start, hold, clear, dec_var,
        input  ref_level, avg_power, est_valid, locked, sym_cnt
    );

    modport slave (
        input  clk_en, start, hold, clear, dec_var,
        output ref_level, avg_power, est_valid, locked, sym_cnt
    );
endinterface

// File: rtl/ref_level_tracker.sv
// ----------------------------------------------------------------------------
// ref_level_tracker
//
// Slicer reference generator for the demodulator back end. Averages |dec_var|
// over self-sequenced windows of 2^WIN_LOG2 symbols, publishes the window mean
// as ref_level, and derives an average-power estimate
// (ref_level^2 * POWER_SCALE) through a two-stage registered multiply pipeline
// that strobes est_valid when avg_power changes.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high; clears all state
//   bus    slave modport of ref_level_tracker_if:
//            clk_en, start, hold, clear, dec_var      (in)
//            ref_level, avg_power, est_valid, locked,
//            sym_cnt                                  (out)
//
// Optional build macro: REF_LEVEL_EMA_EN
//   Undefined (default): ref_level loads the window mean every window.
//   Defined: ref_level follows the window mean through a first-order
//            smoother with gain 2^-ALPHA_LOG2; the first window in ACQ loads
//            the mean directly so lock-in is not slowed down.
// ----------------------------------------------------------------------------
module ref_level_tracker #(
    parameter int                        DATA_W      = 18,
    parameter int                        WIN_LOG2    = 10,
    // Gain in 2s(DATA_W-2) format; the default is 1.25 (4-ASK).
    parameter logic signed [DATA_W-1:0]  POWER_SCALE = 18'sd81920,
    parameter int                        ALPHA_LOG2  = 3
) (
    input  logic               clk,
    input  logic               reset,
    ref_level_tracker_if.slave bus
);
    localparam int ACC_W = DATA_W + WIN_LOG2;
    localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_TRACK
    } state_t;

    // Control / accumulation state
    state_t                     state_q, state_d;
    logic        [ACC_W-1:0]    acc_q, acc_d;
    logic        [WIN_LOG2-1:0] sym_cnt_q, sym_cnt_d;
    logic signed [DATA_W-1:0]   ref_level_q, ref_level_d;
    logic                       locked_q, locked_d;
    logic                       ref_upd_q, ref_upd_d;   // ref_level was written on this edge

    // Power pipeline
    logic signed [DATA_W-1:0]   sq_q;
    logic                       sq_vld_q;
    logic signed [DATA_W-1:0]   avg_power_q;
    logic                       est_valid_q;

    // Datapath
    logic        [DATA_W-1:0]   mag;
    logic        [ACC_W-1:0]    acc_sum;
    logic        [DATA_W-1:0]   new_ref;
    logic        [DATA_W-1:0]   ref_next;
    logic                       advance;
    logic                       accumulate;
    logic                       win_end;
    logic signed [2*DATA_W-1:0] sq_full;
    logic signed [2*DATA_W-1:0] pwr_full;
    logic                       unused_bits;

    // Saturating magnitude: the most-negative code has no positive twin.
    always_comb begin
        if (bus.dec_var == MOST_NEG) begin
            mag = MAG_MAX;
        end else if (bus.dec_var[DATA_W-1]) begin
            mag = DATA_W'(-bus.dec_var);
        end else begin
            mag = bus.dec_var;
        end
    end

    // clear and hold both suppress the sample; everything except the power
    // pipeline moves only on symbol-rate cycles.
    assign advance    = bus.clk_en && !bus.clear && !bus.hold;
    assign accumulate = advance && (state_q != ST_IDLE);
    assign win_end    = accumulate && (sym_cnt_q == '1);

    // Window sum including the sample on this edge. The worst case
    // (2^WIN_LOG2 * (2^(DATA_W-1)-1)) fits ACC_W, so the top DATA_W bits are
    // the mean and the MSB of new_ref is always zero.
    assign acc_sum = acc_q + ACC_W'(mag);
    assign new_ref = acc_sum[ACC_W-1:WIN_LOG2];

`ifdef REF_LEVEL_EMA_EN
    logic signed [DATA_W:0] ema_base;
    logic signed [DATA_W:0] ema_diff;
    logic signed [DATA_W:0] ema_step;
    logic signed [DATA_W:0] ema_sum;
    logic        [DATA_W-1:0] ema_sat;

    // One extra bit of headroom so the difference never wraps; the shift
    // gets its own signed variable so it stays arithmetic.
    always_comb begin
        ema_base = {ref_level_q[DATA_W-1], ref_level_q};
        ema_diff = {1'b0, new_ref} - ema_base;
        ema_step = ema_diff >>> ALPHA_LOG2;
        ema_sum  = ema_base + ema_step;
        if (ema_sum[DATA_W]) begin
            ema_sat = '0;
        end else if (ema_sum[DATA_W-1]) begin
            ema_sat = MAG_MAX;
        end else begin
            ema_sat = ema_sum[DATA_W-1:0];
        end
        ref_next = (state_q == ST_ACQ) ? new_ref : ema_sat;
    end
`else
    assign ref_next = new_ref;
`endif

    // NOTE: every variable driven here gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sym_cnt_d   = sym_cnt_q;
        ref_level_d = ref_level_q;
        locked_d    = locked_q;
        ref_upd_d   = 1'b0;

        if (bus.clk_en && bus.clear) begin
            acc_d     = '0;
            sym_cnt_d = '0;
        end else if (advance) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_ACQ;
                    end
                end
                ST_ACQ, ST_TRACK: begin
                    if (win_end) begin
                        acc_d       = '0;
                        sym_cnt_d   = '0;
                        ref_level_d = ref_next;
                        ref_upd_d   = 1'b1;
                        if (state_q == ST_ACQ) begin
                            state_d  = ST_TRACK;
                            locked_d = 1'b1;
                        end
                    end else begin
                        acc_d     = acc_sum;
                        sym_cnt_d = sym_cnt_q + WIN_LOG2'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Stage operands widened before the multiply so the full product is kept.
    assign sq_full  = (2*DATA_W)'(ref_level_q) * (2*DATA_W)'(ref_level_q);
    assign pwr_full = (2*DATA_W)'(sq_q) * (2*DATA_W)'(POWER_SCALE);

    // Guard and fraction bits dropped by the format conversions.
    assign unused_bits = ^{sq_full[2*DATA_W-1], sq_full[DATA_W-2:0],
                           pwr_full[2*DATA_W-1:2*DATA_W-2], pwr_full[DATA_W-3:0]};

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            sym_cnt_q   <= '0;
            ref_level_q <= '0;
            locked_q    <= 1'b0;
            ref_upd_q   <= 1'b0;
            sq_q        <= '0;
            sq_vld_q    <= 1'b0;
            avg_power_q <= '0;
            est_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sym_cnt_q   <= sym_cnt_d;
            ref_level_q <= ref_level_d;
            locked_q    <= locked_d;
            ref_upd_q   <= ref_upd_d;

            // Free-running pipeline: an update in flight completes whatever
            // clk_en, hold or clear do.
            sq_vld_q    <= ref_upd_q;
            if (ref_upd_q) begin
                sq_q <= sq_full[2*DATA_W-2:DATA_W-1];          // 2s34 -> 1s17
            end
            est_valid_q <= sq_vld_q;
            if (sq_vld_q) begin
                avg_power_q <= pwr_full[2*DATA_W-3:DATA_W-2];  // 3s33 -> 1s17
            end
        end
    end

    assign bus.ref_level = ref_level_q;
    assign bus.avg_power = avg_power_q;
    assign bus.est_valid = est_valid_q;
    assign bus.locked    = locked_q;
    assign bus.sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_ref_level_tracker.sv
// ----------------------------------------------------------------------------
// tb_ref_level_tracker
//
// Drives ref_level_tracker through directed scenarios and a randomized phase.
// A behavioural model (window sum/count, a mode number, and a queue of
// scheduled power updates) predicts every output; a compare process checks all
// outputs against it on every falling edge, and the directed scenarios also
// pin hand-computed literal values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ref_level_tracker;
    localparam int DATA_W     = 18;
    localparam int WIN_LOG2   = 4;
    localparam int ALPHA_LOG2 = 2;
    localparam logic signed [DATA_W-1:0] POWER_SCALE = 18'sd81920;
    localparam int    WIN   = 1 << WIN_LOG2;
    localparam longint MAXV = (64'sd1 <<< (DATA_W-1)) - 1;
    localparam longint MASK = (64'sd1 <<< DATA_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ref_level_tracker_if #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) bus ();

    ref_level_tracker #(
        .DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2),
        .POWER_SCALE(POWER_SCALE), .ALPHA_LOG2(ALPHA_LOG2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int est_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int      m_mode;      // 0 idle, 1 acquiring, 2 tracking
    longint  m_sum;
    int      m_cnt;
    longint  m_ref;
    bit      m_locked;
    longint  m_pow;       // DATA_W-bit pattern of avg_power
    bit      m_est;
    bit      m_ready = 1'b0;
    longint  cyc = 0;
    longint  pend_due[$];
    longint  pend_val[$];

    function automatic longint mag_of(input longint x);
        if (x == -(MAXV + 1)) return MAXV;
        return (x < 0) ? -x : x;
    endfunction

    // ref^2 in 1s17, then times 1.25 (2s16), each result truncated to 18 bits.
    function automatic longint power_of(input longint r);
        longint sq;
        longint p;
        sq = ((r * r) >>> (DATA_W - 1)) & MASK;
        if (sq > MAXV) sq = sq - (MASK + 1);
        p = (sq * longint'(POWER_SCALE)) >>> (DATA_W - 2);
        return p & MASK;
    endfunction

    function automatic longint smooth(input longint old_r, input longint nr);
        longint r;
        r = old_r + ((nr - old_r) >>> ALPHA_LOG2);
        if (r < 0) r = 0;
        if (r > MAXV) r = MAXV;
        return r;
    endfunction

    always @(posedge clk) begin
        longint nr;
        cyc++;
        if (reset) begin
            m_mode = 0; m_sum = 0; m_cnt = 0; m_ref = 0; m_locked = 0;
            m_pow = 0; m_est = 0; m_ready = 1'b1;
            pend_due.delete(); pend_val.delete();
        end else begin
            m_est = 0;
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                m_pow = pend_val.pop_front();
                void'(pend_due.pop_front());
                m_est = 1;
            end
            if (bus.clk_en) begin
                if (bus.clear) begin
                    m_sum = 0; m_cnt = 0;
                end else if (!bus.hold) begin
                    if (m_mode == 0) begin
                        if (bus.start) m_mode = 1;
                    end else begin
                        m_sum += mag_of(longint'(bus.dec_var));
                        m_cnt++;
                        if (m_cnt == WIN) begin
                            nr = m_sum / WIN;
`ifdef REF_LEVEL_EMA_EN
                            m_ref = (m_mode == 2) ? smooth(m_ref, nr) : nr;
`else
                            m_ref = nr;
`endif
                            if (m_mode == 1) begin m_mode = 2; m_locked = 1; end
                            m_sum = 0; m_cnt = 0;
                            pend_due.push_back(cyc + 2);
                            pend_val.push_back(power_of(m_ref));
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (m_ready) begin
            check("ref_level", 64'($unsigned(bus.ref_level)), 64'(m_ref));
            check("avg_power", 64'($unsigned(bus.avg_power)), 64'(m_pow));
            check("est_valid", 64'(bus.est_valid), 64'(m_est));
            check("locked",    64'(bus.locked),    64'(m_locked));
            check("sym_cnt",   64'($unsigned(bus.sym_cnt)), 64'(m_cnt));
            if (bus.est_valid === 1'b1) est_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit en, input bit st, input bit hd, input bit cl, input int dv);
        @(negedge clk);
        bus.clk_en  = en;
        bus.start   = st;
        bus.hold    = hd;
        bus.clear   = cl;
        bus.dec_var = DATA_W'(dv);
    endtask

    task automatic tick(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic samples(input int n, input int dv);
        repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, dv);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.clk_en = 0; bus.start = 0; bus.hold = 0; bus.clear = 0; bus.dec_var = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_state(input string tag, input longint r, input int sc, input bit lk);
        check({tag, " ref_level"}, 64'($unsigned(bus.ref_level)), 64'(r));
        check({tag, " sym_cnt"},   64'($unsigned(bus.sym_cnt)),   64'(sc));
        check({tag, " locked"},    64'(bus.locked),               64'(lk));
    endtask

    // Window edge has just happened; confirm exactly one est pulse and the power value.
    task automatic expect_power(input string tag, input longint p);
        int e0;
        e0 = est_seen;
        tick(3);
        check({tag, " est pulses"}, 64'(est_seen - e0), 64'd1);
        check({tag, " avg_power"}, 64'($unsigned(bus.avg_power)), 64'(p));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv;
        bit en, st, hd, cl, rs;
        reset = 1'b1;
        bus.clk_en = 0; bus.start = 0; bus.hold = 0; bus.clear = 0; bus.dec_var = '0;

        // Reset values
        do_reset();
        expect_state("reset", 0, 0, 0);
        check("reset avg_power", 64'($unsigned(bus.avg_power)), 64'd0);
        check("reset est_valid", 64'(bus.est_valid), 64'd0);

        // First window of +0.5 -> lock, power 0.25*1.25
        drive(1, 1, 0, 0, 0);
        samples(WIN, 65536);
        tick(1);
        expect_state("first window", 65536, 0, 1);
        expect_power("first window", 40960);

        // Alternating sign averages the magnitude
        for (int i = 0; i < WIN; i++) drive(1, 0, 0, 0, (i % 2) ? -65536 : 65536);
        tick(1);
        expect_state("alternating", 65536, 0, 1);
        expect_power("alternating", 40960);

`ifdef REF_LEVEL_EMA_EN
        samples(WIN, 32768);
        tick(1);
        expect_state("ema step 1", 57344, 0, 1);
        samples(WIN, 32768);
        tick(1);
        expect_state("ema step 2", 51200, 0, 1);
        tick(3);
`else
        // Most-negative input saturates to full scale without a sign flip
        samples(WIN, -131072);
        tick(1);
        expect_state("saturate", 131071, 0, 1);
        tick(3);

        // Hold mid-window: held samples are not counted
        samples(8, 65536);
        tick(1);
        check("pre-hold sym_cnt", 64'($unsigned(bus.sym_cnt)), 64'd8);
        repeat (5) drive(1, 0, 1, 0, 131071);
        tick(1);
        expect_state("during hold", 131071, 8, 1);
        samples(7, 65536);
        tick(1);
        expect_state("15 after hold", 131071, 15, 1);
        samples(1, 65536);
        tick(1);
        expect_state("hold window", 65536, 0, 1);
        tick(3);

        // Clear discards the partial window and its own sample
        samples(10, 131071);
        drive(1, 0, 0, 1, 131071);
        tick(1);
        expect_state("after clear", 65536, 0, 1);
        samples(WIN, 32768);
        tick(1);
        expect_state("clear window", 32768, 0, 1);
        expect_power("clear window", 10240);
`endif

        // Reset mid-window returns to IDLE; start is needed again
        samples(5, 32768);
        do_reset();
        expect_state("mid reset", 0, 0, 0);
        check("mid reset avg_power", 64'($unsigned(bus.avg_power)), 64'd0);
        samples(WIN, 65536);
        tick(1);
        expect_state("idle no start", 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        samples(WIN, 65536);
        tick(1);
        expect_state("restart", 65536, 0, 1);
        expect_power("restart", 40960);

        // Randomized phase, checked every cycle by the compare process
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 9) < 7);
            hd = en && ($urandom_range(0, 15) == 0);
            cl = en && ($urandom_range(0, 63) == 0);
            st = !hd && !cl && ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 999) == 0);
            case ($urandom_range(0, 7))
                0:       dv = -131072;
                1:       dv = 131071;
                2:       dv = 0;
                default: dv = int'($urandom_range(0, 262143)) - 131072;
            endcase
            if (rs) begin
                do_reset();
            end else begin
                drive(en, st, hd, cl, dv);
            end
        end
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
